// File: rtl/multiplier3x2_accumulator_pkg.sv
// Shared types and constants for the multiply-accumulate stage.
package multiplier3x2_accumulator_pkg;

  typedef enum logic {
    MULTIPLIER3X2_ACC_ST_ACCUM = 1'b0,
    MULTIPLIER3X2_ACC_ST_DONE  = 1'b1
  } acc_state_e;

  localparam int MULTIPLIER3X2_PRODUCT_W = 5;

endpackage

// File: rtl/multiplier3x2.sv
// Gate-level 3x2 unsigned array multiplier: p = a * b (0..21).
module multiplier3x2 (
  input  logic [2:0] a,
  input  logic [1:0] b,
  output logic [4:0] p
);

  logic pp0_0_s, pp0_1_s, pp0_2_s;
  logic pp1_0_s, pp1_1_s, pp1_2_s;
  logic c1_s, c2_s;

  assign pp0_0_s = a[0] & b[0];
  assign pp0_1_s = a[1] & b[0];
  assign pp0_2_s = a[2] & b[0];
  assign pp1_0_s = a[0] & b[1];
  assign pp1_1_s = a[1] & b[1];
  assign pp1_2_s = a[2] & b[1];

  // Column 1 is a half adder, column 2 a full adder, column 3 a half adder.
  assign p[0] = pp0_0_s;
  assign p[1] = pp0_1_s ^ pp1_0_s;
  assign c1_s = pp0_1_s & pp1_0_s;
  assign p[2] = pp0_2_s ^ pp1_1_s ^ c1_s;
  assign c2_s = (pp0_2_s & pp1_1_s) | (pp0_2_s & c1_s) | (pp1_1_s & c1_s);
  assign p[3] = pp1_2_s ^ c2_s;
  assign p[4] = pp1_2_s & c2_s;

endmodule

// File: rtl/multiplier3x2_accumulator.sv
// Batch multiply-accumulate over a valid/ready stream; result held until taken.
// Define MULTIPLIER3X2_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module multiplier3x2_accumulator
  import multiplier3x2_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH   = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [2:0]             multiplicand,
  input  logic [1:0]             multiplier,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   sum,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  acc_state_e                      state_q, state_d;
  logic [ACC_WIDTH-1:0]            acc_q, acc_d;
  logic [COUNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic                            ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]            sum_q, sum_d;
  logic [COUNT_WIDTH-1:0]          count_q, count_d;
  logic                            overflow_q, overflow_d;

  logic [MULTIPLIER3X2_PRODUCT_W-1:0] product_s;
  logic [ACC_WIDTH:0]                 add_s;
  logic                               carry_s;
  logic [ACC_WIDTH-1:0]               acc_next_s;
  logic [COUNT_WIDTH-1:0]             cnt_inc_s;

  multiplier3x2 u_mult (
    .a (multiplicand),
    .b (multiplier),
    .p (product_s)
  );

  assign add_s   = {1'b0, acc_q}
                 + {{(ACC_WIDTH + 1 - MULTIPLIER3X2_PRODUCT_W){1'b0}}, product_s};
  assign carry_s = add_s[ACC_WIDTH];

  // Overflow policy: clamp at all-ones (sticky, since further adds overflow again) or wrap.
  always_comb begin
    acc_next_s = add_s[ACC_WIDTH-1:0];
`ifdef MULTIPLIER3X2_ACC_SATURATE_EN
    if (carry_s) begin
      acc_next_s = {ACC_WIDTH{1'b1}};
    end else begin
      acc_next_s = add_s[ACC_WIDTH-1:0];
    end
`endif
  end

  assign cnt_inc_s = (cnt_q == {COUNT_WIDTH{1'b1}}) ? cnt_q
                                                     : cnt_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Next-state, working accumulator and result-register updates.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      MULTIPLIER3X2_ACC_ST_ACCUM: begin
        if (in_valid) begin
          if (in_last) begin
            sum_d      = acc_next_s;
            count_d    = cnt_inc_s;
            overflow_d = ovf_q | carry_s;
            acc_d      = {ACC_WIDTH{1'b0}};
            cnt_d      = {COUNT_WIDTH{1'b0}};
            ovf_d      = 1'b0;
            state_d    = MULTIPLIER3X2_ACC_ST_DONE;
          end else begin
            acc_d = acc_next_s;
            cnt_d = cnt_inc_s;
            ovf_d = ovf_q | carry_s;
          end
        end else begin
          state_d = MULTIPLIER3X2_ACC_ST_ACCUM;
        end
      end
      MULTIPLIER3X2_ACC_ST_DONE: begin
        if (out_ready) begin
          state_d = MULTIPLIER3X2_ACC_ST_ACCUM;
        end else begin
          state_d = MULTIPLIER3X2_ACC_ST_DONE;
        end
      end
      default: begin
        state_d = MULTIPLIER3X2_ACC_ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= MULTIPLIER3X2_ACC_ST_ACCUM;
      acc_q      <= {ACC_WIDTH{1'b0}};
      cnt_q      <= {COUNT_WIDTH{1'b0}};
      ovf_q      <= 1'b0;
      sum_q      <= {ACC_WIDTH{1'b0}};
      count_q    <= {COUNT_WIDTH{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == MULTIPLIER3X2_ACC_ST_ACCUM);
  assign out_valid = (state_q == MULTIPLIER3X2_ACC_ST_DONE);
  assign sum       = sum_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_multiplier3x2_accumulator.sv
// Directed self-checking bench for multiplier3x2_accumulator (ACC_WIDTH=8, COUNT_WIDTH=4).
module tb_multiplier3x2_accumulator;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [2:0] multiplicand;
  logic [1:0] multiplier;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic [3:0] count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  multiplier3x2_accumulator #(
    .ACC_WIDTH   (8),
    .COUNT_WIDTH (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum          (sum),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents one pair for one cycle; inputs change 1 time unit after the edge.
  task automatic send(input logic [2:0] a, input logic [1:0] b, input logic last);
    multiplicand = a;
    multiplier   = b;
    in_last      = last;
    in_valid     = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    multiplicand = 3'd0;
    multiplier   = 2'd0;
    out_ready    = 1'b1;
    tick();
    tick();

    check("rst_sum",       32'(sum),       32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset_n = 1'b1;
    tick();

    // 6 + 5 + 21 = 32
    send(3'd3, 2'd2, 1'b0);
    send(3'd5, 2'd1, 1'b0);
    send(3'd7, 2'd3, 1'b1);
    check("b1_out_valid", 32'(out_valid), 32'd1);
    check("b1_in_ready",  32'(in_ready),  32'd0);
    check("b1_sum",       32'(sum),       32'd32);
    check("b1_count",     32'(count),     32'd3);
    check("b1_overflow",  32'(overflow),  32'd0);
    tick();
    check("b1_out_valid_drop", 32'(out_valid), 32'd0);
    check("b1_in_ready_back",  32'(in_ready),  32'd1);
    check("b1_sum_held",       32'(sum),       32'd32);

    // 13 * 21 = 273: wraps to 17 or clamps to 255
    for (int i = 0; i < 13; i++) begin
      send(3'd7, 2'd3, (i == 12) ? 1'b1 : 1'b0);
    end
`ifdef MULTIPLIER3X2_ACC_SATURATE_EN
    check("ovf_sum", 32'(sum), 32'd255);
`else
    check("ovf_sum", 32'(sum), 32'd17);
`endif
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd13);
    tick();

    send(3'd0, 2'd3, 1'b1);
    check("single0_sum",   32'(sum),   32'd0);
    check("single0_count", 32'(count), 32'd1);
    check("single0_ovf",   32'(overflow), 32'd0);
    tick();
    send(3'd7, 2'd1, 1'b1);
    check("single7_sum",   32'(sum),   32'd7);
    check("single7_count", 32'(count), 32'd1);
    tick();

    // Backpressure: 6 + 2 = 8, an input pulse in DONE must be ignored
    out_ready = 1'b0;
    send(3'd2, 2'd3, 1'b0);
    send(3'd1, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      multiplicand = 3'd7;
      multiplier   = 2'd3;
      in_last      = 1'b1;
      in_valid     = (i == 1) ? 1'b1 : 1'b0;
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_sum",       32'(sum),       32'd8);
      check("bp_count",     32'(count),     32'd2);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    send(3'd1, 2'd1, 1'b1);
    check("bp_next_sum",   32'(sum),   32'd1);
    check("bp_next_count", 32'(count), 32'd1);
    tick();

    // Mid-batch reset discards partial accumulation
    send(3'd7, 2'd3, 1'b0);
    send(3'd7, 2'd3, 1'b0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_sum",      32'(sum),      32'd0);
    check("mid_rst_count",    32'(count),    32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    send(3'd1, 2'd1, 1'b1);
    check("mid_rst_after_sum",   32'(sum),   32'd1);
    check("mid_rst_after_count", 32'(count), 32'd1);
    check("mid_rst_after_ovf",   32'(overflow), 32'd0);
    tick();

    // Count saturates at 15 while the sum keeps growing
    for (int i = 0; i < 20; i++) begin
      send(3'd1, 2'd1, (i == 19) ? 1'b1 : 1'b0);
    end
    check("sat_count", 32'(count),    32'd15);
    check("sat_sum",   32'(sum),      32'd20);
    check("sat_ovf",   32'(overflow), 32'd0);

    // Reset while holding a result in DONE
    out_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("done_rst_out_valid", 32'(out_valid), 32'd0);
    check("done_rst_sum",       32'(sum),       32'd0);
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
